// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between the CPU datapath and DMem.
// Handles one request at a time. Sub-word stores become read-modify-write
// because DMem only writes whole words. Illegal, misaligned and out-of-range
// requests are answered with resp_err and never reach DMem.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | req_ready=1, waiting for a request
// RD     | dmem_re=1: load data or old word for a sub-word store
// WR     | dmem_we=1: full word (SW) or merged word (SB/SH) written
// RESP   | resp_valid=1 for one cycle, then back to IDLE
module mem_access_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_we,
  output logic        dmem_re,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  localparam logic [31:0] LP_ADDR_LIMIT = 32'(MEM_WORDS * 4);

  localparam logic [1:0] LP_SZ_BYTE = 2'b00;
  localparam logic [1:0] LP_SZ_HALF = 2'b01;
  localparam logic [1:0] LP_SZ_WORD = 2'b10;
  localparam logic [1:0] LP_SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_RESP = 2'b11
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic        r_dmem_we;
  logic        r_dmem_re;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;

  logic        w_accept;
  logic        w_misalign;
  logic        w_illegal;
  logic        w_out_of_range;
  logic        w_req_err;
  logic [31:0] w_word_addr;
  logic [7:0]  w_load_byte;
  logic [15:0] w_load_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign dmem_we    = r_dmem_we;
  assign dmem_re    = r_dmem_re;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;

  // Legality of the incoming request, evaluated in the acceptance cycle
  always_comb begin
    w_accept       = req_valid && r_req_ready;
    w_illegal      = (req_size == LP_SZ_ILL);
    w_misalign     = ((req_size == LP_SZ_HALF) && req_addr[0]) ||
                     ((req_size == LP_SZ_WORD) && (req_addr[1:0] != 2'b00));
    w_out_of_range = (req_addr >= LP_ADDR_LIMIT);
    w_req_err      = w_illegal || w_misalign || w_out_of_range;
    w_word_addr    = {req_addr[31:2], 2'b00};
  end

  // Lane extraction and sign/zero extension of the word read in RD
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_load_byte = dmem_rdata[7:0];
      2'd1:    w_load_byte = dmem_rdata[15:8];
      2'd2:    w_load_byte = dmem_rdata[23:16];
      default: w_load_byte = dmem_rdata[31:24];
    endcase
    w_load_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_size)
      LP_SZ_BYTE: w_load_data = r_unsigned ? {24'h000000, w_load_byte}
                                           : {{24{w_load_byte[7]}}, w_load_byte};
      LP_SZ_HALF: w_load_data = r_unsigned ? {16'h0000, w_load_half}
                                           : {{16{w_load_half[15]}}, w_load_half};
      default:    w_load_data = dmem_rdata;
    endcase
  end

  // Replace only the addressed lane of the old word for SB/SH
  always_comb begin
    w_merged = dmem_rdata;
    case (r_size)
      LP_SZ_BYTE: begin
        case (r_addr[1:0])
          2'd0:    w_merged[7:0]   = r_wdata[7:0];
          2'd1:    w_merged[15:8]  = r_wdata[7:0];
          2'd2:    w_merged[23:16] = r_wdata[7:0];
          default: w_merged[31:24] = r_wdata[7:0];
        endcase
      end
      LP_SZ_HALF: begin
        if (r_addr[1]) begin
          w_merged[31:16] = r_wdata[15:0];
        end else begin
          w_merged[15:0] = r_wdata[15:0];
        end
      end
      default: w_merged = r_wdata;
    endcase
  end

  // Request sequencer; every output is a flop so DMem strobes are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_re    <= 1'b0;
      r_dmem_addr  <= 32'h0;
      r_dmem_wdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= req_we;
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            if (w_req_err) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'h0;
            end else if (req_we && (req_size == LP_SZ_WORD)) begin
              r_state      <= S_WR;
              r_dmem_we    <= 1'b1;
              r_dmem_addr  <= w_word_addr;
              r_dmem_wdata <= req_wdata;
            end else begin
              // Loads and sub-word stores both start by reading the word
              r_state      <= S_RD;
              r_dmem_re    <= 1'b1;
              r_dmem_addr  <= w_word_addr;
              r_dmem_wdata <= 32'h0;
            end
          end
        end
        S_RD: begin
          r_dmem_re <= 1'b0;
          if (r_we) begin
            r_state      <= S_WR;
            r_dmem_we    <= 1'b1;
            r_dmem_wdata <= w_merged;
          end else begin
            r_state      <= S_RESP;
            r_dmem_addr  <= 32'h0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_load_data;
          end
        end
        S_WR: begin
          r_state      <= S_RESP;
          r_dmem_we    <= 1'b0;
          r_dmem_addr  <= 32'h0;
          r_dmem_wdata <= 32'h0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'h0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'h0;
          r_dmem_we    <= 1'b0;
          r_dmem_re    <= 1'b0;
          r_dmem_addr  <= 32'h0;
          r_dmem_wdata <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of directed load/store vectors against a
// behavioural word memory, plus hand sequences for reset corner cases.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dmem_we;
  logic        dmem_re;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  logic [31:0] mem [0:1023];

  int n_vec;
  int n_cmp;
  int n_fail;

  mem_access_unit #(.MEM_WORDS(1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .dmem_we      (dmem_we),
    .dmem_re      (dmem_re),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-wide DMem model: combinational read, write on the rising edge
  assign dmem_rdata = dmem_re ? mem[dmem_addr[11:2]] : 32'h0;
  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr[11:2]] <= dmem_wdata;
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_nwe;
    int          exp_nre;
    logic        chk_mem;
    logic [31:0] exp_mem;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [NV];

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic e, input int lat,
                              input int nw, input int nr, input logic cm,
                              input logic [31:0] em);
    vec_t v;
    v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = e; v.exp_lat = lat;
    v.exp_nwe = nw; v.exp_nre = nr; v.chk_mem = cm; v.exp_mem = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge
  task automatic apply(input vec_t v, input int idx);
    int  cyc;
    int  nwe;
    int  nre;
    logic got;
    string tag;
    tag = $sformatf("v%0d", idx);
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'h0;
    cyc = 0; nwe = 0; nre = 0; got = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (dmem_we) nwe++;
      if (dmem_re) nre++;
      if (dmem_we || dmem_re)
        check({tag, ".dmem_addr"}, dmem_addr, {v.addr[31:2], 2'b00});
      if (resp_valid) got = 1'b1;
      else check({tag, ".we_re_excl"}, {31'h0, dmem_we & dmem_re}, 32'h0);
    end
    check({tag, ".latency"}, got ? cyc : 99, v.exp_lat);
    check({tag, ".rdata"}, resp_rdata, v.exp_rdata);
    check({tag, ".err"}, {31'h0, resp_err}, {31'h0, v.exp_err});
    check({tag, ".n_we"}, nwe, v.exp_nwe);
    check({tag, ".n_re"}, nre, v.exp_nre);
    check({tag, ".resp_dmem_idle"}, {dmem_we, dmem_re, 30'h0} | dmem_addr | dmem_wdata, 32'h0);
    @(negedge clk);
    check({tag, ".pulse_ready"}, {30'h0, resp_valid, req_ready}, 32'h1);
    if (v.chk_mem)
      check({tag, ".mem"}, mem[v.addr[11:2]], v.exp_mem);
    n_vec++;
  endtask

  initial begin
    int bad;
    n_vec = 0; n_cmp = 0; n_fail = 0;
    rst_n = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;

    //            we  sz     u     addr           wdata          rdata          err  lat nw nr chk  mem
    vt[0]  = mk(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'h0,         1'b0, 2, 1, 0, 1'b1, 32'hDEADBEEF);
    vt[1]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF,  1'b0, 2, 0, 1, 1'b0, 32'h0);
    vt[2]  = mk(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00AA, 32'h0,        1'b0, 3, 1, 1, 1'b1, 32'hAAADBEEF);
    vt[3]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        32'hFFFFFFAA,  1'b0, 2, 0, 1, 1'b0, 32'h0);
    vt[4]  = mk(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,        32'h000000AA,  1'b0, 2, 0, 1, 1'b0, 32'h0);
    vt[5]  = mk(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_1234, 32'h0,        1'b0, 3, 1, 1, 1'b1, 32'h1234BEEF);
    vt[6]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,        32'h00001234,  1'b0, 2, 0, 1, 1'b0, 32'h0);
    vt[7]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,        32'hFFFFBEEF,  1'b0, 2, 0, 1, 1'b0, 32'h0);
    vt[8]  = mk(1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,        32'h0000BEEF,  1'b0, 2, 0, 1, 1'b0, 32'h0);
    vt[9]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_0011, 32'h0,        32'h0,         1'b1, 1, 0, 0, 1'b0, 32'h0);
    vt[10] = mk(1'b1, 2'b01, 1'b0, 32'h0000_0013, 32'h0000_5678, 32'h0,        1'b1, 1, 0, 0, 1'b1, 32'h1234BEEF);
    vt[11] = mk(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        32'h0,         1'b1, 1, 0, 0, 1'b0, 32'h0);
    vt[12] = mk(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0,        32'h0,         1'b1, 1, 0, 0, 1'b0, 32'h0);
    vt[13] = mk(1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'hFFFFFF55, 32'h0,         1'b0, 3, 1, 1, 1'b1, 32'h123455EF);
    vt[14] = mk(1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'h0000_007E, 32'h0,        1'b0, 3, 1, 1, 1'b1, 32'h1234557E);
    vt[15] = mk(1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        32'h00000055,  1'b0, 2, 0, 1, 1'b0, 32'h0);
    vt[16] = mk(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0,        32'h0000007E,  1'b0, 2, 0, 1, 1'b0, 32'h0);
    vt[17] = mk(1'b1, 2'b10, 1'b0, 32'h0000_0FFC, 32'h80000001, 32'h0,         1'b0, 2, 1, 0, 1'b1, 32'h80000001);
    vt[18] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0,        32'h80000001,  1'b0, 2, 0, 1, 1'b0, 32'h0);
    vt[19] = mk(1'b0, 2'b01, 1'b0, 32'h0000_0FFE, 32'h0,        32'hFFFF8000,  1'b0, 2, 0, 1, 1'b0, 32'h0);
    vt[20] = mk(1'b0, 2'b01, 1'b1, 32'h0000_0FFE, 32'h0,        32'h00008000,  1'b0, 2, 0, 1, 1'b0, 32'h0);
    vt[21] = mk(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h12345678, 32'h0,         1'b1, 1, 0, 0, 1'b0, 32'h0);
    vt[22] = mk(1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0000_9999, 32'h0,        1'b1, 1, 0, 0, 1'b1, 32'h1234557E);
    vt[23] = mk(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h11223344, 32'h0,         1'b0, 2, 1, 0, 1'b1, 32'h11223344);

    // Asynchronous reset before any clock edge
    #3;
    rst_n = 1'b0;
    #1;
    check("reset.ready", {31'h0, req_ready}, 32'h1);
    check("reset.strobes", {29'h0, resp_valid, dmem_we, dmem_re}, 32'h0);
    check("reset.resp", resp_rdata | {31'h0, resp_err}, 32'h0);
    check("reset.dmem_bus", dmem_addr | dmem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) apply(vt[i], i);

    // Reset during the RD phase of SB 0x20: no write, no response
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0000_0020; req_wdata = 32'h0000_00AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    check("rstmid.in_rd", {30'h0, dmem_re, dmem_we}, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid.strobes", {29'h0, resp_valid, dmem_we, dmem_re}, 32'h0);
    check("rstmid.ready", {31'h0, req_ready}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid || dmem_we || dmem_re || !req_ready) bad++;
    end
    check("rstmid.quiet_after", bad, 0);
    check("rstmid.mem_untouched", mem[8], 32'h11223344);
    n_vec++;

    apply(mk(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 32'h11223344, 1'b0, 2, 0, 1, 1'b0, 32'h0), 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
